imem_ctrl: RTL and testbench
============================

Name: imem_ctrl

Overview:
Controller that sequences a single-port, synchronous-read instruction RAM (word-organised, REG_SIZE bits per word) for the single-cycle core.
After reset it runs a boot-load phase: a program-loader stream writes consecutive words starting at word 0.
It then enters run phase and serves core fetches with a valid/ready handshake, 1-cycle read latency and address checking.
It sits between the core PC/fetch logic and the instruction RAM, and is the RAM's only master.

Parameters:
REG_SIZE, 32, width of address, instruction and load-data words
MEM_SIZE_IN_KB, 1, RAM capacity in KiB
NO_OF_REGS, MEM_SIZE_IN_KB*1024/4, RAM depth in words
AW, $clog2(NO_OF_REGS), word-index width driven to RAM

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  synchronous active-high reset
ld_valid_i  input  1  loader word valid
ld_data_i  input  REG_SIZE  loader instruction word
ld_last_i  input  1  marks final loader word
ld_ready_o  output  1  controller accepts loader word this cycle
fetch_req_i  input  1  core fetch request
fetch_addr_i  input  REG_SIZE  byte address (PC)
fetch_ready_o  output  1  request accepted this cycle
fetch_valid_o  output  1  fetch response valid
fetch_inst_o  output  REG_SIZE  fetched instruction
fetch_err_o  output  1  response is an error (misaligned / out of range); qualified by fetch_valid_o
run_o  output  1  high in RUN state
mem_addr_o  output  AW  RAM word index
mem_we_o  output  1  RAM write enable
mem_wdata_o  output  REG_SIZE  RAM write data
mem_rdata_i  input  REG_SIZE  RAM read data, valid the cycle after the read address is presented

Behaviour:
- Clock and reset are decided: one clock, clk; reset is rst, synchronous and active-high. Everything below is sampled on rising clk edges.
- Reset values: state=LOAD, load pointer=0, ld_ready_o=1, fetch_ready_o=0, fetch_valid_o=0, fetch_err_o=0, fetch_inst_o=0, run_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
- A rst asserted mid-load or mid-fetch aborts it: no write is performed in that cycle, and a pending response is dropped (fetch_valid_o=0 next cycle).
- LOAD state:
  - ld_ready_o=1 and fetch_ready_o=0.
  - On ld_valid_i&&ld_ready_o: mem_we_o=1, mem_addr_o=ptr, mem_wdata_o=ld_data_i (combinational to RAM, written that edge), then ptr<=ptr+1.
  - ld_last_i on an accepted word -> RUN next cycle.
  - Word accepted at ptr=NO_OF_REGS-1 without ld_last_i -> still written, then forced to RUN; further loader words are ignored (ld_ready_o=0). No wrap-around.
  - ld_valid_i low -> no write; ptr holds.
- RUN state:
  - run_o=1, ld_ready_o=0, mem_we_o=0 always.
  - fetch_ready_o=1 every cycle; the controller is fully pipelined, one request per cycle.
  - Accepted request (fetch_req_i&&fetch_ready_o): mem_addr_o=fetch_addr_i[AW+1:2].
  - Next cycle: fetch_valid_o=1 and fetch_inst_o=mem_rdata_i. Latency is exactly 1 cycle.
  - Error case: fetch_addr_i[1:0]!=0, or fetch_addr_i>>2 >= NO_OF_REGS. Then next cycle fetch_valid_o=1, fetch_err_o=1, fetch_inst_o=32'h00000013 (NOP). RAM read is still issued but its data is discarded.
  - No request -> fetch_valid_o=0 next cycle; fetch_inst_o holds its last value.
- LOAD->RUN transition cycle: fetch_ready_o becomes 1 in the first RUN cycle, never earlier.

Optional Feature:
IMEM_RELOAD_EN:
- Defined:
  - Adds input ld_start_i. In RUN, ld_start_i=1 -> state LOAD next cycle, ptr<=0, fetch_ready_o=0 from that cycle.
  - A fetch accepted in the same cycle as ld_start_i still completes its response next cycle.
  - run_o drops together with fetch_ready_o.
- Undefined: no ld_start_i port; RUN is terminal until rst.

Test Plan:
1. rst for 2 cycles, then load 4 words 0x00500093,0x00A00113,0x002081B3,0x00000013 with ld_last_i on the 4th -> mem writes at indices 0..3; run_o=1 the cycle after the 4th word.
2. After test 1, fetch addrs 0x0,0x4,0x8,0xC back-to-back -> fetch_valid_o 1 cycle later each, returning those 4 words in order, no bubbles.
3. Fetch addr 0x6 -> fetch_valid_o=1, fetch_err_o=1, fetch_inst_o=0x00000013. Fetch addr 0x400 (NO_OF_REGS=256) -> same error response.
4. Loader with ld_valid_i toggling 1,0,1 while in LOAD -> only 2 writes (indices 0,1); ptr holds in the idle cycle; fetch_ready_o=0 throughout LOAD.
5. Stream 256 words with no ld_last_i -> last write at index 255, then RUN; a 257th ld_valid_i is not accepted (ld_ready_o=0).
6. Assert rst in the cycle a fetch is accepted -> fetch_valid_o=0 next cycle; state=LOAD, ptr=0. With IMEM_RELOAD_EN: ld_start_i in RUN -> LOAD, a reload rewrites word 0, and a subsequent fetch of 0x0 returns the new word.

Source files
------------

// File: rtl/imem_ctrl.sv
// Instruction RAM controller: boot-load phase writes loader words from index 0, then the run phase serves pipelined core fetches.
// Optional macro IMEM_RELOAD_EN adds ld_start_i so that RUN can re-enter LOAD without a reset.
module imem_ctrl #(
    parameter int REG_SIZE       = 32,
    parameter int MEM_SIZE_IN_KB = 1,
    parameter int NO_OF_REGS     = MEM_SIZE_IN_KB * 1024 / 4,
    parameter int AW             = $clog2(NO_OF_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_valid_i,
    input  logic [REG_SIZE-1:0] ld_data_i,
    input  logic                ld_last_i,
    output logic                ld_ready_o,
`ifdef IMEM_RELOAD_EN
    input  logic                ld_start_i,
`endif
    input  logic                fetch_req_i,
    input  logic [REG_SIZE-1:0] fetch_addr_i,
    output logic                fetch_ready_o,
    output logic                fetch_valid_o,
    output logic [REG_SIZE-1:0] fetch_inst_o,
    output logic                fetch_err_o,
    output logic                run_o,
    output logic [AW-1:0]       mem_addr_o,
    output logic                mem_we_o,
    output logic [REG_SIZE-1:0] mem_wdata_o,
    input  logic [REG_SIZE-1:0] mem_rdata_i
);

    localparam logic [AW-1:0]       LAST_IDX = AW'(NO_OF_REGS - 1);
    localparam logic [REG_SIZE-1:0] NOP_INST = REG_SIZE'(32'h0000_0013);

    typedef enum logic {LOAD, RUN} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic                vld_q, vld_d;
    logic                err_q, err_d;
    logic [REG_SIZE-1:0] inst_hold_q;
    logic                addr_bad;
    logic [REG_SIZE-1:0] resp_inst;

    assign addr_bad = (|fetch_addr_i[1:0])
                    || (fetch_addr_i[REG_SIZE-1:2] >= (REG_SIZE-2)'(NO_OF_REGS));

    // Response data is taken straight from the RAM output in the cycle after the read.
    assign resp_inst     = err_q ? NOP_INST : mem_rdata_i;
    assign fetch_valid_o = vld_q;
    assign fetch_err_o   = err_q;
    assign fetch_inst_o  = vld_q ? resp_inst : inst_hold_q;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        vld_d         = 1'b0;
        err_d         = 1'b0;
        ld_ready_o    = 1'b0;
        fetch_ready_o = 1'b0;
        run_o         = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        if (rst) begin
            ld_ready_o = 1'b1;
        end else begin
            case (state_q)
                LOAD: begin
                    ld_ready_o = 1'b1;
                    mem_addr_o = ptr_q;
                    if (ld_valid_i) begin
                        mem_we_o    = 1'b1;
                        mem_wdata_o = ld_data_i;
                        // The final RAM index ends the load even without ld_last_i; no wrap-around.
                        if (ptr_q != LAST_IDX) ptr_d = ptr_q + 1'b1;
                        if (ld_last_i || ptr_q == LAST_IDX) state_d = RUN;
                    end
                end
                RUN: begin
                    run_o         = 1'b1;
                    fetch_ready_o = 1'b1;
                    if (fetch_req_i) begin
                        mem_addr_o = fetch_addr_i[AW+1:2];
                        vld_d      = 1'b1;
                        err_d      = addr_bad;
                    end
`ifdef IMEM_RELOAD_EN
                    if (ld_start_i) begin
                        state_d = LOAD;
                        ptr_d   = '0;
                    end
`endif
                end
                default: state_d = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            ptr_q       <= '0;
            vld_q       <= 1'b0;
            err_q       <= 1'b0;
            inst_hold_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            if (vld_q) inst_hold_q <= resp_inst;
        end
    end

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl with a behavioural synchronous-read RAM attached.
// Covers reset, boot load, pipelined fetch, error responses, load gaps, overflow load and reset abort.
module tb_imem_ctrl;
    localparam int RS  = 32;
    localparam int NR  = 256;
    localparam int AW  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid_i, ld_last_i, ld_ready_o;
    logic [RS-1:0] ld_data_i;
    logic          fetch_req_i, fetch_ready_o, fetch_valid_o, fetch_err_o, run_o;
    logic [RS-1:0] fetch_addr_i, fetch_inst_o;
    logic [AW-1:0] mem_addr_o;
    logic          mem_we_o;
    logic [RS-1:0] mem_wdata_o, mem_rdata_i;
`ifdef IMEM_RELOAD_EN
    logic          ld_start_i;
`endif

    int errors = 0;
    int checks = 0;

    logic [RS-1:0] ram [NR];
    logic [RS-1:0] words [4];

    imem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ld_valid_i   (ld_valid_i),
        .ld_data_i    (ld_data_i),
        .ld_last_i    (ld_last_i),
        .ld_ready_o   (ld_ready_o),
`ifdef IMEM_RELOAD_EN
        .ld_start_i   (ld_start_i),
`endif
        .fetch_req_i  (fetch_req_i),
        .fetch_addr_i (fetch_addr_i),
        .fetch_ready_o(fetch_ready_o),
        .fetch_valid_o(fetch_valid_o),
        .fetch_inst_o (fetch_inst_o),
        .fetch_err_o  (fetch_err_o),
        .run_o        (run_o),
        .mem_addr_o   (mem_addr_o),
        .mem_we_o     (mem_we_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
        mem_rdata_i <= ram[mem_addr_o];
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_valid_i   = 1'b0;
        ld_data_i    = '0;
        ld_last_i    = 1'b0;
        fetch_req_i  = 1'b0;
        fetch_addr_i = '0;
`ifdef IMEM_RELOAD_EN
        ld_start_i   = 1'b0;
`endif
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        checks++;
        if ({ld_ready_o, fetch_ready_o, fetch_valid_o, fetch_err_o, run_o, mem_we_o} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 100000",
                     {ld_ready_o, fetch_ready_o, fetch_valid_o, fetch_err_o, run_o, mem_we_o});
        end
        checks++;
        if (fetch_inst_o !== 32'h0 || mem_addr_o !== 8'h0 || mem_wdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: inst=%h addr=%h wdata=%h want all zero", fetch_inst_o, mem_addr_o, mem_wdata_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_load();
        for (int i = 0; i < 4; i++) begin
            ld_valid_i = 1'b1;
            ld_data_i  = words[i];
            ld_last_i  = (i == 3);
            #1;
            checks++;
            if (mem_we_o !== 1'b1 || mem_addr_o !== AW'(i) || mem_wdata_o !== words[i] || fetch_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL load_write%0d: we=%b addr=%0d wdata=%h frdy=%b want 1 %0d %h 0",
                         i, mem_we_o, mem_addr_o, mem_wdata_o, fetch_ready_o, i, words[i]);
            end
            cyc();
        end
        idle_inputs();
        #1;
        checks++;
        if (run_o !== 1'b1 || fetch_ready_o !== 1'b1 || ld_ready_o !== 1'b0 || mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL load_to_run: run=%b frdy=%b lrdy=%b we=%b want 1 1 0 0", run_o, fetch_ready_o, ld_ready_o, mem_we_o);
        end
        checks++;
        if (ram[3] !== words[3] || ram[0] !== words[0]) begin
            errors++;
            $display("FAIL load_ram: ram0=%h ram3=%h want %h %h", ram[0], ram[3], words[0], words[3]);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            fetch_req_i  = (i < 4);
            fetch_addr_i = 32'(4 * i);
            if (i < 4) begin
                #1;
                checks++;
                if (mem_addr_o !== AW'(i)) begin
                    errors++;
                    $display("FAIL fetch_addr%0d: got %0d want %0d", i, mem_addr_o, i);
                end
            end
            cyc();
            if (i < 4) begin
                checks++;
                if (fetch_valid_o !== 1'b1 || fetch_err_o !== 1'b0 || fetch_inst_o !== words[i]) begin
                    errors++;
                    $display("FAIL fetch_resp%0d: vld=%b err=%b inst=%h want 1 0 %h", i, fetch_valid_o, fetch_err_o, fetch_inst_o, words[i]);
                end
            end else begin
                checks++;
                if (fetch_valid_o !== 1'b0 || fetch_inst_o !== words[3]) begin
                    errors++;
                    $display("FAIL fetch_idle: vld=%b inst=%h want 0 %h", fetch_valid_o, fetch_inst_o, words[3]);
                end
            end
        end
    endtask

    task automatic test_error();
        logic [RS-1:0] addrs [3];
        logic [RS-1:0] exp_inst [3];
        logic          exp_err [3];
        addrs[0] = 32'h6;   exp_err[0] = 1'b1; exp_inst[0] = 32'h0000_0013;
        addrs[1] = 32'h400; exp_err[1] = 1'b1; exp_inst[1] = 32'h0000_0013;
        addrs[2] = 32'h4;   exp_err[2] = 1'b0; exp_inst[2] = 32'h00A0_0113;
        for (int i = 0; i < 3; i++) begin
            fetch_req_i  = 1'b1;
            fetch_addr_i = addrs[i];
            cyc();
            checks++;
            if (fetch_valid_o !== 1'b1 || fetch_err_o !== exp_err[i] || fetch_inst_o !== exp_inst[i]) begin
                errors++;
                $display("FAIL err_resp_%h: vld=%b err=%b inst=%h want 1 %b %h",
                         addrs[i], fetch_valid_o, fetch_err_o, fetch_inst_o, exp_err[i], exp_inst[i]);
            end
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_load_gaps();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        ld_valid_i = 1'b1; ld_data_i = 32'h1111_1111;
        #1;
        checks++;
        if (mem_we_o !== 1'b1 || mem_addr_o !== 8'd0) begin
            errors++;
            $display("FAIL gap_w0: we=%b addr=%0d want 1 0", mem_we_o, mem_addr_o);
        end
        cyc();
        ld_valid_i = 1'b0;
        #1;
        checks++;
        if (mem_we_o !== 1'b0 || fetch_ready_o !== 1'b0 || ld_ready_o !== 1'b1 || run_o !== 1'b0) begin
            errors++;
            $display("FAIL gap_idle: we=%b frdy=%b lrdy=%b run=%b want 0 0 1 0", mem_we_o, fetch_ready_o, ld_ready_o, run_o);
        end
        cyc();
        ld_valid_i = 1'b1; ld_data_i = 32'h2222_2222; ld_last_i = 1'b1;
        #1;
        checks++;
        if (mem_we_o !== 1'b1 || mem_addr_o !== 8'd1 || fetch_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL gap_w1: we=%b addr=%0d frdy=%b want 1 1 0", mem_we_o, mem_addr_o, fetch_ready_o);
        end
        cyc();
        idle_inputs();
        checks++;
        if (run_o !== 1'b1 || ram[1] !== 32'h2222_2222 || ram[2] !== words[2]) begin
            errors++;
            $display("FAIL gap_end: run=%b ram1=%h ram2=%h want 1 22222222 %h", run_o, ram[1], ram[2], words[2]);
        end
    endtask

    task automatic test_overflow();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) begin
            ld_valid_i = 1'b1;
            ld_data_i  = 32'hA500_0000 + 32'(i);
            #1;
            if (i == 0 || i == NR - 1) begin
                checks++;
                if (mem_we_o !== 1'b1 || mem_addr_o !== AW'(i) || run_o !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_w%0d: we=%b addr=%0d run=%b want 1 %0d 0", i, mem_we_o, mem_addr_o, run_o, i);
                end
            end
            cyc();
        end
        ld_data_i = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (run_o !== 1'b1 || ld_ready_o !== 1'b0 || mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_257: run=%b lrdy=%b we=%b want 1 0 0", run_o, ld_ready_o, mem_we_o);
        end
        cyc();
        idle_inputs();
        checks++;
        if (ram[255] !== 32'hA500_00FF || ram[0] !== 32'hA500_0000) begin
            errors++;
            $display("FAIL ovf_ram: ram255=%h ram0=%h want a50000ff a5000000", ram[255], ram[0]);
        end
    endtask

    task automatic test_rst_abort();
        fetch_req_i  = 1'b1;
        fetch_addr_i = 32'h8;
        ld_valid_i   = 1'b1;
        rst          = 1'b1;
        #1;
        checks++;
        if (mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_we: got %b want 0", mem_we_o);
        end
        cyc();
        rst = 1'b0;
        idle_inputs();
        checks++;
        if (fetch_valid_o !== 1'b0 || run_o !== 1'b0 || ld_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_state: vld=%b run=%b lrdy=%b want 0 0 1", fetch_valid_o, run_o, ld_ready_o);
        end
        ld_valid_i = 1'b1; ld_data_i = 32'h0BAD_F00D; ld_last_i = 1'b1;
        #1;
        checks++;
        if (mem_we_o !== 1'b1 || mem_addr_o !== 8'd0) begin
            errors++;
            $display("FAIL abort_ptr: we=%b addr=%0d want 1 0", mem_we_o, mem_addr_o);
        end
        cyc();
        idle_inputs();
    endtask

`ifdef IMEM_RELOAD_EN
    task automatic test_reload();
        fetch_req_i  = 1'b1;
        fetch_addr_i = 32'h0;
        ld_start_i   = 1'b1;
        #1;
        checks++;
        if (fetch_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reload_rdy: got %b want 1", fetch_ready_o);
        end
        cyc();
        idle_inputs();
        checks++;
        if (fetch_valid_o !== 1'b1 || fetch_inst_o !== 32'h0BAD_F00D || run_o !== 1'b0 || fetch_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reload_enter: vld=%b inst=%h run=%b frdy=%b want 1 0badf00d 0 0",
                     fetch_valid_o, fetch_inst_o, run_o, fetch_ready_o);
        end
        ld_valid_i = 1'b1; ld_data_i = 32'hDEAD_BEEF; ld_last_i = 1'b1;
        cyc();
        idle_inputs();
        fetch_req_i = 1'b1;
        fetch_addr_i = 32'h0;
        cyc();
        idle_inputs();
        checks++;
        if (fetch_valid_o !== 1'b1 || fetch_inst_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL reload_fetch: vld=%b inst=%h want 1 deadbeef", fetch_valid_o, fetch_inst_o);
        end
    endtask
`endif

    initial begin
        words[0] = 32'h0050_0093;
        words[1] = 32'h00A0_0113;
        words[2] = 32'h0020_81B3;
        words[3] = 32'h0000_0013;
        for (int i = 0; i < NR; i++) ram[i] = '0;
        mem_rdata_i = '0;
        test_reset();
        test_load();
        test_back_to_back();
        test_error();
        test_load_gaps();
        test_overflow();
        test_rst_abort();
`ifdef IMEM_RELOAD_EN
        test_reload();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
